// File: rtl/digct_seq_monitor_if.sv
// Handshake and sample bundle between the upstream stage, the sequence
// monitor and the event consumer.
interface digct_seq_monitor_if #(
  parameter int unsigned CNT_W = 8
);

  localparam int unsigned CODE_W = 3;

  // Sample side from the upstream stage
  logic              EN;
  logic              CLR;
  logic [CODE_W-1:0] IN_CODE;

  // Event side towards the consumer
  logic              EVT_VALID;
  logic              EVT_READY;
  logic [CNT_W-1:0]  EVT_COUNT;
  logic              OVERFLOW;
  logic              EVT_LOST;

  // Producer/consumer view: drives samples and ready, observes events
  modport master (
    output EN,
    output CLR,
    output IN_CODE,
    output EVT_READY,
    input  EVT_VALID,
    input  EVT_COUNT,
    input  OVERFLOW,
    input  EVT_LOST
  );

  // Monitor view
  modport slave (
    input  EN,
    input  CLR,
    input  IN_CODE,
    input  EVT_READY,
    output EVT_VALID,
    output EVT_COUNT,
    output OVERFLOW,
    output EVT_LOST
  );

endinterface

// File: rtl/digct_seq_monitor.sv
// Watches the upstream 3-bit output vector for the code sequence A -> B -> C
// on consecutive enabled samples, counts matches (saturating) and reports
// each match as a valid/ready event carrying the post-increment count.
module digct_seq_monitor #(
  parameter int unsigned CNT_W  = 8,
  parameter logic [2:0]  CODE_A = 3'b101,
  parameter logic [2:0]  CODE_B = 3'b011,
  parameter logic [2:0]  CODE_C = 3'b110
) (
  input  logic                     CLK,
  input  logic                     RST,
  digct_seq_monitor_if.slave       bus
);

  localparam int unsigned           CODE_W  = 3;
  localparam logic [CNT_W-1:0]      CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GOT_A  = 2'd1,
    S_GOT_AB = 2'd2
  } state_e;

  // Input aliases
  logic              en;
  logic              clr;
  logic [CODE_W-1:0] in_code;
  logic              evt_ready;

  assign en        = bus.EN;
  assign clr       = bus.CLR;
  assign in_code   = bus.IN_CODE;
  assign evt_ready = bus.EVT_READY;

  // State
  state_e           state_q,     state_d;
  logic [CNT_W-1:0] count_q,     count_d;
  logic             evt_valid_q, evt_valid_d;
  logic [CNT_W-1:0] evt_count_q, evt_count_d;
  logic             overflow_q,  overflow_d;
  logic             evt_lost_q,  evt_lost_d;

  // Combinational helpers
  logic             detect_c;
  logic             accept_c;
  logic [CNT_W-1:0] count_new_c;

  // Match condition, consumed at the same edge it is seen
  always_comb begin
    detect_c = en && (state_q == S_GOT_AB) && (in_code == CODE_C);
    accept_c = evt_valid_q && evt_ready;
  end

  // Sequence tracker: advances only on enabled samples, holds otherwise
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = S_IDLE;
    end else if (en) begin
      unique case (state_q)
        S_IDLE: begin
          if (in_code == CODE_A) state_d = S_GOT_A;
          else                   state_d = S_IDLE;
        end
        S_GOT_A: begin
          if      (in_code == CODE_B) state_d = S_GOT_AB;
          else if (in_code == CODE_A) state_d = S_GOT_A;
          else                        state_d = S_IDLE;
        end
        S_GOT_AB: begin
          // A completed match restarts; the C code may itself begin a new one
          if (in_code == CODE_A) state_d = S_GOT_A;
          else                   state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Saturating match counter with sticky overflow
  always_comb begin
    count_new_c = count_q;
    if (count_q != CNT_MAX) begin
      count_new_c = count_q + CNT_W'(1);
    end
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clr) begin
      count_d    = '0;
      overflow_d = 1'b0;
    end else if (detect_c) begin
      count_d = count_new_c;
      if (count_new_c == CNT_MAX) begin
        overflow_d = 1'b1;
      end
    end
  end

  // Event register: load on detect when free or being accepted, else flag loss
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_count_d = evt_count_q;
    evt_lost_d  = evt_lost_q;
    if (clr) begin
      evt_valid_d = 1'b0;
      evt_count_d = '0;
      evt_lost_d  = 1'b0;
    end else if (detect_c) begin
      if (!evt_valid_q || accept_c) begin
        evt_valid_d = 1'b1;
        evt_count_d = count_new_c;
      end else begin
        evt_lost_d  = 1'b1;
      end
    end else if (accept_c) begin
      evt_valid_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      evt_valid_q <= 1'b0;
      evt_count_q <= '0;
      overflow_q  <= 1'b0;
      evt_lost_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      evt_valid_q <= evt_valid_d;
      evt_count_q <= evt_count_d;
      overflow_q  <= overflow_d;
      evt_lost_q  <= evt_lost_d;
    end
  end

  // Registered outputs
  assign bus.EVT_VALID = evt_valid_q;
  assign bus.EVT_COUNT = evt_count_q;
  assign bus.OVERFLOW  = overflow_q;
  assign bus.EVT_LOST  = evt_lost_q;

endmodule

// File: tb/tb_digct_seq_monitor.sv
// Directed bench for digct_seq_monitor: a full-width instance checked through
// an event scoreboard, plus a 2-bit-counter instance for saturation.
module tb_digct_seq_monitor;

  localparam logic [2:0] A = 3'b101;
  localparam logic [2:0] B = 3'b011;
  localparam logic [2:0] C = 3'b110;

  logic CLK;
  logic RST;

  digct_seq_monitor_if #(.CNT_W(8)) bus8 ();
  digct_seq_monitor_if #(.CNT_W(2)) bus2 ();

  digct_seq_monitor #(.CNT_W(8)) u_dut8 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus8)
  );

  digct_seq_monitor #(.CNT_W(2)) u_dut2 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, score any handshake completing at this edge,
  // then advance to just after the edge.
  task automatic cyc(input logic en, input logic [2:0] code, input logic rdy, input logic clr);
    int unsigned exp;
    bus8.EN = en;  bus8.IN_CODE = code; bus8.EVT_READY = rdy; bus8.CLR = clr;
    bus2.EN = en;  bus2.IN_CODE = code; bus2.EVT_READY = rdy; bus2.CLR = clr;
    #1;
    if (bus8.EVT_VALID && bus8.EVT_READY) begin
      chk("sb_evt_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        exp = sb_q.pop_front();
        chk("sb_evt_count", 32'(bus8.EVT_COUNT), exp);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic seq(input logic rdy);
    cyc(1'b1, A, rdy, 1'b0);
    cyc(1'b1, B, rdy, 1'b0);
    cyc(1'b1, C, rdy, 1'b0);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_valid"},    32'(bus8.EVT_VALID), 32'd0);
    chk({tag, "_count"},    32'(bus8.EVT_COUNT), 32'd0);
    chk({tag, "_overflow"}, 32'(bus8.OVERFLOW),  32'd0);
    chk({tag, "_lost"},     32'(bus8.EVT_LOST),  32'd0);
    chk({tag, "_ovf2"},     32'(bus2.OVERFLOW),  32'd0);
  endtask

  initial begin
    RST = 1'b1;
    bus8.EN = 1'b0; bus8.CLR = 1'b0; bus8.IN_CODE = '0; bus8.EVT_READY = 1'b0;
    bus2.EN = 1'b0; bus2.CLR = 1'b0; bus2.IN_CODE = '0; bus2.EVT_READY = 1'b0;
    repeat (2) @(posedge CLK);
    #3 RST = 1'b0;
    @(posedge CLK); #1;
    chk_cleared("reset");

    // Basic match, single-cycle event one cycle after C is sampled
    cyc(1'b1, A, 1'b1, 1'b0);
    cyc(1'b1, B, 1'b1, 1'b0);
    chk("t1_valid_before", 32'(bus8.EVT_VALID), 32'd0);
    sb_q.push_back(1);
    cyc(1'b1, C, 1'b1, 1'b0);
    chk("t1_valid_after_c", 32'(bus8.EVT_VALID), 32'd1);
    chk("t1_count", 32'(bus8.EVT_COUNT), 32'd1);
    cyc(1'b0, 3'b000, 1'b1, 1'b0);
    chk("t1_valid_one_cycle", 32'(bus8.EVT_VALID), 32'd0);
    chk("t1_overflow", 32'(bus8.OVERFLOW), 32'd0);
    chk("t1_lost", 32'(bus8.EVT_LOST), 32'd0);

    // A re-entry still matches; a repeated B breaks the sequence
    cyc(1'b0, 3'b000, 1'b1, 1'b1);
    cyc(1'b1, A, 1'b1, 1'b0);
    sb_q.push_back(1);
    seq(1'b1);
    cyc(1'b0, 3'b000, 1'b1, 1'b0);
    cyc(1'b1, A, 1'b1, 1'b0);
    cyc(1'b1, B, 1'b1, 1'b0);
    cyc(1'b1, B, 1'b1, 1'b0);
    cyc(1'b1, C, 1'b1, 1'b0);
    chk("t2_no_detect", 32'(bus8.EVT_VALID), 32'd0);
    chk("t2_count_kept", 32'(bus8.EVT_COUNT), 32'd1);

    // Disabled gap holds a partial match; disabled codes are ignored
    cyc(1'b0, 3'b000, 1'b1, 1'b1);
    cyc(1'b1, A, 1'b1, 1'b0);
    repeat (5) cyc(1'b0, C, 1'b1, 1'b0);
    chk("t3_gap_no_event", 32'(bus8.EVT_VALID), 32'd0);
    cyc(1'b1, B, 1'b1, 1'b0);
    sb_q.push_back(1);
    cyc(1'b1, C, 1'b1, 1'b0);
    chk("t3_gap_detect", 32'(bus8.EVT_VALID), 32'd1);
    cyc(1'b0, 3'b000, 1'b1, 1'b0);

    // Async reset with a pending event and a partial match
    seq(1'b0);
    cyc(1'b1, A, 1'b0, 1'b0);
    cyc(1'b1, B, 1'b0, 1'b0);
    RST = 1'b1;
    #2;
    chk("t3_rst_async_valid", 32'(bus8.EVT_VALID), 32'd0);
    chk("t3_rst_async_count", 32'(bus8.EVT_COUNT), 32'd0);
    #2 RST = 1'b0;
    @(posedge CLK); #1;
    cyc(1'b1, C, 1'b1, 1'b0);
    chk("t3_rst_no_detect", 32'(bus8.EVT_VALID), 32'd0);

    // Back-pressure: second detect is lost, counter keeps counting
    cyc(1'b0, 3'b000, 1'b0, 1'b1);
    sb_q.push_back(1);
    seq(1'b0);
    seq(1'b0);
    chk("t4_valid_held", 32'(bus8.EVT_VALID), 32'd1);
    chk("t4_count_held", 32'(bus8.EVT_COUNT), 32'd1);
    chk("t4_lost", 32'(bus8.EVT_LOST), 32'd1);
    cyc(1'b0, 3'b000, 1'b1, 1'b0);
    chk("t4_accepted", 32'(bus8.EVT_VALID), 32'd0);
    sb_q.push_back(3);
    seq(1'b1);
    chk("t4_third_count", 32'(bus8.EVT_COUNT), 32'd3);
    cyc(1'b0, 3'b000, 1'b1, 1'b0);
    chk("t4_lost_sticky", 32'(bus8.EVT_LOST), 32'd1);

    // Detect in the cycle the pending event is accepted replaces it
    cyc(1'b0, 3'b000, 1'b0, 1'b1);
    sb_q.push_back(1);
    seq(1'b0);
    cyc(1'b1, A, 1'b0, 1'b0);
    cyc(1'b1, B, 1'b0, 1'b0);
    sb_q.push_back(2);
    cyc(1'b1, C, 1'b1, 1'b0);
    chk("t6_b2b_valid", 32'(bus8.EVT_VALID), 32'd1);
    chk("t6_b2b_count", 32'(bus8.EVT_COUNT), 32'd2);
    chk("t6_b2b_lost", 32'(bus8.EVT_LOST), 32'd0);
    cyc(1'b0, 3'b000, 1'b1, 1'b0);

    // Saturation on the 2-bit counter instance
    cyc(1'b0, 3'b000, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      sb_q.push_back(i);
      seq(1'b1);
      chk("t5_cnt2_count", 32'(bus2.EVT_COUNT), (i >= 3) ? 32'd3 : 32'(i));
      chk("t5_cnt2_overflow", 32'(bus2.OVERFLOW), (i >= 3) ? 32'd1 : 32'd0);
    end
    cyc(1'b0, 3'b000, 1'b1, 1'b0);
    chk("t5_cnt2_overflow_held", 32'(bus2.OVERFLOW), 32'd1);

    // Clear on the same edge as a detect wins over everything
    seq(1'b0);
    seq(1'b0);
    chk("t7_lost_before_clr", 32'(bus8.EVT_LOST), 32'd1);
    cyc(1'b1, A, 1'b0, 1'b0);
    cyc(1'b1, B, 1'b0, 1'b0);
    cyc(1'b1, C, 1'b0, 1'b1);
    chk_cleared("t7_clr");
    // Clear also returns the tracker to idle
    cyc(1'b1, A, 1'b1, 1'b0);
    cyc(1'b1, B, 1'b1, 1'b1);
    cyc(1'b1, C, 1'b1, 1'b0);
    chk("t7_fsm_idle", 32'(bus8.EVT_VALID), 32'd0);
    sb_q.push_back(1);
    seq(1'b1);
    chk("t7_restart_count", 32'(bus8.EVT_COUNT), 32'd1);
    cyc(1'b0, 3'b000, 1'b1, 1'b0);
    cyc(1'b0, 3'b000, 1'b1, 1'b0);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/digct_seq_monitor.md
Name: digct_seq_monitor

Overview:
- Downstream consumer of the registered 3-bit output vector {OUT3,OUT2,OUT1} of the simple digital circuit stage.
- Watches that vector for a fixed three-code sequence A -> B -> C on consecutive enabled cycles and counts matches.
- Reports each match as an event carrying the running match count over a valid/ready handshake.
- Flags count saturation and events lost to back-pressure.

Parameters:
CODE_A, 3'b101, first code of sequence
CODE_B, 3'b011, second code of sequence
CODE_C, 3'b110, third code of sequence
CNT_W, 8, width of match counter and EVT_COUNT

Ports:
CLK  in  1  rising-edge clock
RST  in  1  asynchronous active-high reset
EN  in  1  sample enable; IN_CODE considered only when 1
CLR  in  1  synchronous clear of counter, flags and pending event; FSM to IDLE
IN_CODE  in  3  {OUT3,OUT2,OUT1} from upstream stage
EVT_VALID  out  1  event pending
EVT_READY  in  1  consumer accepts event when EVT_VALID=1
EVT_COUNT  out  CNT_W  match count captured at detection (post-increment)
OVERFLOW  out  1  sticky: counter reached all-ones
EVT_LOST  out  1  sticky: detection occurred while an unaccepted event was pending

Behaviour:
- One clock CLK; reset RST asynchronous, active-high. All state updates on rising CLK edge.
- Reset/CLR values: FSM=IDLE, count=0, EVT_VALID=0, EVT_COUNT=0, OVERFLOW=0, EVT_LOST=0. CLR has priority over every other update.
- FSM has three states: IDLE, GOT_A, GOT_AB. It advances only on edges with EN=1 and holds when EN=0. A gap of any length with EN=0 does not break a partial match.
- IDLE: code==A -> GOT_A; otherwise IDLE.
- GOT_A: code==B -> GOT_AB; code==A -> GOT_A; otherwise IDLE.
- GOT_AB: code==C -> detect, then go to IDLE (GOT_A if C==A). Otherwise: code==A -> GOT_A, else IDLE.
- Detect is a combinational condition (EN & state==GOT_AB & IN_CODE==C) and is consumed at the same edge. Latency: EVT_VALID is high in the cycle after the edge that samples C.
- Counter on detect: if count != all-ones, count <= count+1. If count+1 == all-ones, OVERFLOW <= 1. At all-ones the count saturates with no wrap.
- Event register on detect:
  - If EVT_VALID=0, or EVT_VALID & EVT_READY in the same cycle: EVT_VALID <= 1 and EVT_COUNT <= new count. Back-to-back events need no idle cycle.
  - If EVT_VALID & ~EVT_READY: the pending event and EVT_COUNT are held unchanged and EVT_LOST <= 1. The counter still increments.
- No detect and EVT_VALID & EVT_READY: EVT_VALID <= 0. EVT_COUNT keeps its last value.
- While EVT_VALID=1 and EVT_READY=0, EVT_COUNT is stable.
- EVT_READY is ignored when EVT_VALID=0.
- Reset mid-sequence or mid-handshake: everything returns to reset values immediately (asynchronous). The partial match and pending event are discarded.
- The minimum detection interval is 3 enabled cycles.

Test Plan:
- RST pulse, then EN=1, IN_CODE 101,011,110, EVT_READY=1 -> EVT_VALID high for exactly 1 cycle, one cycle after 110 sampled; EVT_COUNT=1; OVERFLOW=0; EVT_LOST=0.
- Sequence 101,101,011,110 -> one detect (GOT_A re-entry), EVT_COUNT=1. Sequence 101,011,011,110 -> no detect.
- 101, EN=0 for 5 cycles, 011, 110 -> detect, EVT_COUNT=1. Then RST asserted after 101,011 -> next 110 does not detect.
- EVT_READY=0, two full sequences -> EVT_VALID stays 1, EVT_COUNT=1, EVT_LOST=1, internal count 2. Raise EVT_READY for 1 cycle, then a third sequence -> EVT_COUNT=3.
- CNT_W=2, four sequences with EVT_READY=1 -> EVT_COUNT 1,2,3,3; OVERFLOW set at third detect and held.
- CLR=1 on the same edge as a detect -> count=0, EVT_VALID=0, flags 0, FSM=IDLE.
